// File: rtl/avalon_word_ram.sv
`default_nettype none
// ============================================================================
// Module   : avalon_word_ram
// Brief    : Avalon-MM word memory slave with fixed-latency pipelined reads,
//            a pending-read limit and an optional periodic stall injector.
// Revision : 1.0
// ============================================================================
module avalon_word_ram #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic              slave_waitrequest
);

  localparam int                  C_DEPTH    = 2 ** ADDR_W;
  localparam int                  C_PEND_W   = $clog2(MAX_PENDING + 1);
  localparam logic [C_PEND_W-1:0] C_PEND_MAX = C_PEND_W'(MAX_PENDING);

  logic [DATA_W-1:0]       r_mem [C_DEPTH];
  logic [ADDR_W-1:0]       w_idx;
  logic                    w_stall;
  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic [C_PEND_W-1:0]     r_pending;
  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]       r_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] w_stg_vld;
  logic [DATA_W-1:0]       w_stg_dat [READ_LATENCY];
  logic                    w_unused_addr;

  // Byte lane bits and bits above the array size are dropped, so addresses wrap.
  assign w_idx         = slave_address[ADDR_W+1:2];
  assign w_unused_addr = ^{slave_address[31:ADDR_W+2], slave_address[1:0]};

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int                   C_STALL_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(STALL_PERIOD - 1);

      logic [C_STALL_W-1:0] r_stall_cnt;

      // Free-running: the stall pattern is independent of traffic.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt == C_STALL_LAST) begin
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + C_STALL_W'(1);
        end
      end

      assign w_stall = (r_stall_cnt == C_STALL_LAST);
    end else begin : g_no_stall
      assign w_stall = 1'b0;
    end
  endgenerate

  assign slave_waitrequest = !rst_n || (r_pending == C_PEND_MAX) || w_stall;

  // A write wins over a simultaneous read; the read is dropped entirely.
  assign w_acc_wr = slave_write && !slave_waitrequest;
  assign w_acc_rd = slave_read && !slave_write && !slave_waitrequest;

  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      r_mem[w_idx] <= slave_writedata;
    end
  end

  always_comb begin
    w_stg_vld[0] = w_acc_rd;
    w_stg_dat[0] = r_mem[w_idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      w_stg_vld[i] = r_vld[i-1];
      w_stg_dat[i] = r_dat[i-1];
    end
  end

  // Data moves only alongside a valid, so the last stage holds its value between returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= w_stg_vld;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (!rst_n) begin
        r_dat[i] <= '0;
      end else if (w_stg_vld[i]) begin
        r_dat[i] <= w_stg_dat[i];
      end
    end
  end

  assign slave_readdatavalid = r_vld[READ_LATENCY-1];
  assign slave_readdata      = r_dat[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (w_acc_rd && !slave_readdatavalid) begin
      r_pending <= r_pending + C_PEND_W'(1);
    end else if (!w_acc_rd && slave_readdatavalid) begin
      r_pending <= r_pending - C_PEND_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_word_ram.sv
`default_nettype none
// Bench for avalon_word_ram: four instances with different latency/stall settings,
// each checked every cycle against a queue-based reference model.
module tb_avalon_word_ram;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n   [4];
  logic [31:0] s_addr  [4];
  logic        s_rd    [4];
  logic        s_wr    [4];
  logic [31:0] s_wd    [4];
  logic [31:0] rdata   [4];
  logic        rvalid  [4];
  logic        wreq    [4];
  logic [31:0] cap     [4][$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int k, input int w);
    return 32'hC0DE_0000 | 32'(k << 8) | 32'(w);
  endfunction

  function automatic logic [31:0] cap_at(input int k, input int i);
    if (i < cap[k].size()) return cap[k][i];
    return 32'hFFFF_FFFF;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int L  = (gi == 0) ? 2 : (gi == 1) ? 8 : 4;
    localparam int S  = (gi == 2) ? 3 : 0;
    localparam int SD = (S > 0) ? S : 1;
    localparam int MP = 4;

    avalon_word_ram #(
      .ADDR_W(10), .DATA_W(32), .READ_LATENCY(L), .MAX_PENDING(MP), .STALL_PERIOD(S)
    ) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n[gi]),
      .slave_address       (s_addr[gi]),
      .slave_read          (s_rd[gi]),
      .slave_write         (s_wr[gi]),
      .slave_writedata     (s_wd[gi]),
      .slave_readdata      (rdata[gi]),
      .slave_readdatavalid (rvalid[gi]),
      .slave_waitrequest   (wreq[gi])
    );

    // Reference: outstanding reads as a queue of (due cycle, data).
    rd_t         q[$];
    logic [31:0] mmem [1024];
    logic [31:0] cyc   = 0;
    logic [31:0] since = 0;
    logic [31:0] last  = 0;
    bit          live  = 0;

    function automatic bit exp_wreq();
      return !rst_n[gi] || (q.size() == MP) || ((S > 0) && ((since % SD) == SD - 1));
    endfunction

    always @(posedge clk) begin
      bit  ew;
      rd_t e;
      ew = exp_wreq();
      if (q.size() > 0 && q[0].due == cyc) begin
        last = q[0].data;
        void'(q.pop_front());
      end
      if (!rst_n[gi]) begin
        q.delete();
        since = 0;
        last  = 0;
        live  = 1;
      end else begin
        if (!ew && s_wr[gi]) begin
          mmem[s_addr[gi][11:2]] = s_wd[gi];
        end else if (!ew && s_rd[gi]) begin
          e.due  = cyc + L;
          e.data = mmem[s_addr[gi][11:2]];
          q.push_back(e);
        end
        since++;
      end
      cyc++;
    end

    always @(negedge clk) begin
      bit          ev;
      logic [31:0] ed;
      if (live) begin
        ev = (q.size() > 0) && (q[0].due == cyc);
        ed = ev ? q[0].data : last;
        check("waitrequest", gi, 32'(wreq[gi]), 32'(exp_wreq()));
        check("readdatavalid", gi, 32'(rvalid[gi]), 32'(ev));
        check("readdata", gi, rdata[gi], ed);
        if (rvalid[gi]) cap[gi].push_back(rdata[gi]);
      end
    end
  end

  task automatic idle(input int k);
    s_rd[k] = 1'b0;
    s_wr[k] = 1'b0;
  endtask

  // Drives a request and returns #1 after the edge that accepted it.
  task automatic xfer(input int k, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    s_rd[k] = rd; s_wr[k] = wr; s_addr[k] = a; s_wd[k] = d;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = !wreq[k];
      @(posedge clk);
      #1;
    end
    check("xfer_accept", k, 32'(acc), 32'd1);
  endtask

  task automatic wait_caps(input int k, input int n);
    for (int t = 0; t < 300 && cap[k].size() < n; t++) begin
      @(posedge clk);
      #1;
    end
    check("capture_count", k, 32'(cap[k].size() >= n), 32'd1);
  endtask

  task automatic read_word(input int k, input logic [31:0] a, output logic [31:0] d);
    int n0;
    n0 = cap[k].size();
    xfer(k, 1'b1, 1'b0, a, 32'd0);
    idle(k);
    wait_caps(k, n0 + 1);
    d = cap_at(k, n0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, r;
    int          n0, nacc, nwait, lat;
    logic [31:0] mask;
    bit          seen;

    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0; s_rd[k] = 1'b0; s_wr[k] = 1'b0; s_addr[k] = '0; s_wd[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("reset_valid", k, 32'(rvalid[k]), 32'd0);
      check("reset_rdata", k, rdata[k], 32'd0);
      check("reset_wreq", k, 32'(wreq[k]), 32'd1);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("wreq_after_reset", k, 32'(wreq[k]), 32'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 64; w++) xfer(k, 1'b0, 1'b1, 32'(w * 4), pat(k, w));
      idle(k);
    end

    // Single word write then read, latency 2.
    xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    n0 = cap[0].size();
    xfer(0, 1'b1, 1'b0, 32'h10, 32'd0);
    idle(0);
    lat = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rvalid[0]) break;
      lat++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("rd_latency", 0, 32'(lat), 32'd2);
    check("rd_data", 0, cap_at(0, n0), 32'hDEAD_BEEF);

    // Fill, copy via back-to-back reads, verify destination.
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 1'b1, 32'(i * 4), 32'(i * 3 + 1));
    n0 = cap[0].size();
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, 1'b0, 32'(i * 4), 32'd0);
    idle(0);
    wait_caps(0, n0 + 16);
    for (int i = 0; i < 16; i++) check("copy_src", 0, cap_at(0, n0 + i), 32'(i * 3 + 1));
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 1'b1, 32'((16 + i) * 4), cap_at(0, n0 + i));
    idle(0);
    for (int i = 0; i < 16; i++) begin
      read_word(0, 32'((16 + i) * 4), d);
      check("copy_dst", 0, d, 32'(i * 3 + 1));
    end

    // Pending limit: latency 8, four outstanding reads.
    nacc = 0; nwait = 0; seen = 1'b0;
    s_rd[1] = 1'b1;
    for (int t = 0; t < 30; t++) begin
      s_addr[1] = 32'((40 + nacc) * 4);
      @(negedge clk);
      if (!seen && rvalid[1]) seen = 1'b1;
      if (!seen) begin
        if (!wreq[1]) nacc++;
        else nwait++;
      end
      @(posedge clk);
      #1;
    end
    idle(1);
    cycles(20);
    check("pend_accepts", 1, 32'(nacc), 32'd4);
    check("pend_wait_cycles", 1, 32'(nwait), 32'd4);
    check("pend_returned", 1, 32'(seen), 32'd1);

    // Stall injection, period 3, started right after a reset.
    rst_n[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    s_wr[2]  = 1'b1;
    mask     = '0;
    for (int i = 0; i < 10; i++) begin
      s_addr[2] = 32'((48 + i) * 4);
      s_wd[2]   = 32'hA000 + 32'(i);
      @(negedge clk);
      if (wreq[2]) mask = mask | (32'd1 << i);
      @(posedge clk);
      #1;
    end
    idle(2);
    check("stall_mask", 2, mask, 32'h124);
    check("stall_accepts", 2, 32'(10 - $countones(mask)), 32'd7);
    for (int i = 0; i < 10; i++) begin
      read_word(2, 32'((48 + i) * 4), d);
      check("stall_word", 2, d, (i % 3 == 2) ? pat(2, 48 + i) : 32'hA000 + 32'(i));
    end

    // Simultaneous read and write: write wins, no return.
    xfer(0, 1'b1, 1'b1, 32'h20, 32'h55);
    idle(0);
    n0 = cap[0].size();
    cycles(12);
    check("rw_no_valid", 0, 32'(cap[0].size()), 32'(n0));
    read_word(0, 32'h20, d);
    check("rw_word8", 0, d, 32'h55);

    // Reset with three reads in flight, latency 4.
    n0 = cap[3].size();
    xfer(3, 1'b1, 1'b0, 32'd20, 32'd0);
    xfer(3, 1'b1, 1'b0, 32'd24, 32'd0);
    xfer(3, 1'b1, 1'b0, 32'd28, 32'd0);
    idle(3);
    rst_n[3] = 1'b0;
    @(negedge clk);
    check("rst_wreq", 3, 32'(wreq[3]), 32'd1);
    @(posedge clk);
    #1;
    rst_n[3] = 1'b1;
    cycles(15);
    check("rst_no_return", 3, 32'(cap[3].size()), 32'(n0));
    read_word(3, 32'd20, d);
    check("rst_mem_kept", 3, d, pat(3, 5));

    // Random traffic, upper and byte address bits randomised.
    for (int k = 0; k < 4; k++) begin
      for (int it = 0; it < 200; it++) begin
        r = $urandom;
        a = $urandom;
        a[11:8] = 4'd0;
        case (r[1:0])
          2'd0, 2'd1: xfer(k, 1'b1, 1'b0, a, $urandom);
          2'd2:       xfer(k, 1'b0, 1'b1, a, $urandom);
          default:    xfer(k, 1'b1, 1'b1, a, $urandom);
        endcase
        if (r[4:3] == 2'd0) begin
          idle(k);
          cycles(1);
        end
      end
      idle(k);
      cycles(30);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
